marin_soc: RTL and testbench

// Top level of the Marin demo SoC, the only block under the top simulation wrapper.

---
 rtl/marin_soc.sv | 151 +++++++++++++++
 tb/tb_marin_soc.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/marin_soc.sv
// Marin demo SoC top: after reset, sends the "MARIN\r\n" banner once over UART 8N1
// and shows progress, a heartbeat and completion on the LEDs and done_o.
module marin_soc #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HB_BIT       = 25
) (
  input  logic       clk_100mhz_i,
  input  logic       rst_i,
  output logic       uart_tx_o,
  output logic [7:0] leds_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_NEXT,
    S_DONE
  } state_e;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  sent_q, sent_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] hb_q, hb_d;
  logic        tx_q, tx_d;
  logic [7:0]  leds_q, leds_d;
  logic        done_q, done_d;
  logic        baud_last;

  function automatic logic [7:0] banner_rom(input logic [2:0] i);
    case (i)
      3'd0:    banner_rom = 8'h4D;
      3'd1:    banner_rom = 8'h41;
      3'd2:    banner_rom = 8'h52;
      3'd3:    banner_rom = 8'h49;
      3'd4:    banner_rom = 8'h4E;
      3'd5:    banner_rom = 8'h0D;
      default: banner_rom = 8'h0A;
    endcase
  endfunction

  assign baud_last = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    shift_d = shift_q;
    hb_d    = hb_q + 32'd1;
    case (state_q)
      S_LOAD: begin
        shift_d = banner_rom(idx_q);
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          state_d = S_NEXT;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_NEXT: begin
        sent_d = (sent_q == 3'd7) ? 3'd7 : sent_q + 3'd1;
        if (idx_q == 3'd6) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // Outputs are registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    leds_d = {hb_q[HB_BIT], 4'b0000, sent_q};
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk_100mhz_i) begin
    if (rst_i) begin
      state_q <= S_LOAD;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      idx_q   <= 3'd0;
      sent_q  <= 3'd0;
      shift_q <= 8'hFF;
      hb_q    <= 32'd0;
      tx_q    <= 1'b1;
      leds_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      shift_q <= shift_d;
      hb_q    <= hb_d;
      tx_q    <= tx_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx_o = tx_q;
  assign leds_o    = leds_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_marin_soc.sv
// Directed bench for marin_soc: reset values, bit-accurate first frame, banner
// decode through an expected-byte queue, heartbeat, done timing, idle and mid-frame reset.
module tb_marin_soc;

  localparam int CPB    = 4;
  localparam int HB     = 3;
  localparam int PERIOD = 10 * CPB + 2;

  logic       clk_100mhz_i;
  logic       rst_i;
  logic       uart_tx_o;
  logic [7:0] leds_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;
  int e      = -1;
  logic [7:0] exp_q[$];
  logic [7:0] banner[7];

  marin_soc #(.CLKS_PER_BIT(CPB), .HB_BIT(HB)) dut (
    .clk_100mhz_i(clk_100mhz_i),
    .rst_i       (rst_i),
    .uart_tx_o   (uart_tx_o),
    .leds_o      (leds_o),
    .done_o      (done_o)
  );

  initial clk_100mhz_i = 1'b0;
  always #4 clk_100mhz_i = ~clk_100mhz_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge E%0d)", tag, obs, exp, e);
    end
  endtask

  // Advance to just after edge E<n> (sampled on the falling edge).
  task automatic goto(input int n);
    bit moved;
    moved = 1'b0;
    while (e < n) begin
      @(posedge clk_100mhz_i);
      e++;
      moved = 1'b1;
    end
    if (moved) @(negedge clk_100mhz_i);
  endtask

  function automatic logic line_model(input int o, input logic [7:0] d);
    if (o >= 1 && o <= 4 * 1 + CPB - 4) return 1'b0;
    if (o >= 1 + CPB && o <= 9 * CPB) return d[(o - 1 - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic pop_compare(input string tag, input logic [7:0] rx);
    logic [7:0] exp_b;
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, {24'd0, rx}, {24'd0, exp_b});
  endtask

  task automatic recv_frame(input int b);
    int base;
    logic [7:0] rx;
    base = b * PERIOD;
    goto(base + 2);
    check("start_bit", {31'd0, uart_tx_o}, 32'd0);
    check("sent_count", {29'd0, leds_o[2:0]}, b);
    for (int k = 0; k < 8; k++) begin
      goto(base + 1 + (k + 1) * CPB + CPB / 2);
      rx[k] = uart_tx_o;
    end
    goto(base + 1 + 9 * CPB + CPB / 2);
    check("stop_bit", {31'd0, uart_tx_o}, 32'd1);
    pop_compare("banner_byte", rx);
  endtask

  task automatic release_reset;
    rst_i = 1'b0;
    e = -1;
  endtask

  initial begin
    logic [7:0] rx0;
    banner = '{8'h4D, 8'h41, 8'h52, 8'h49, 8'h4E, 8'h0D, 8'h0A};
    rst_i = 1'b0;
    repeat (125) @(negedge clk_100mhz_i);
    rst_i = 1'b1;
    repeat (125) begin
      @(negedge clk_100mhz_i);
      check("reset_vals", {22'd0, uart_tx_o, leds_o, done_o}, {22'd0, 1'b1, 8'h00, 1'b0});
    end

    release_reset();
    foreach (banner[i]) exp_q.push_back(banner[i]);

    // First frame, edge by edge, with heartbeat on leds_o[7].
    for (int n = 0; n <= PERIOD; n++) begin
      goto(n);
      check("frame0_line", {31'd0, uart_tx_o}, {31'd0, line_model(n, 8'h4D)});
      check("heartbeat", {31'd0, leds_o[7]}, (n >> HB) & 1);
      check("leds_zero", {28'd0, leds_o[6:3]}, 32'd0);
      if (n >= 1 + CPB && n <= 9 * CPB && ((n - 1) % CPB) == CPB / 2)
        rx0[(n - 1 - CPB) / CPB] = uart_tx_o;
      if (n == PERIOD - 1) check("count_before", {29'd0, leds_o[2:0]}, 32'd0);
      if (n == PERIOD)     check("count_after", {29'd0, leds_o[2:0]}, 32'd1);
    end
    pop_compare("banner_byte", rx0);

    for (int b = 1; b < 7; b++) recv_frame(b);

    goto(7 * PERIOD - 1);
    check("done_early", {31'd0, done_o}, 32'd0);
    goto(7 * PERIOD);
    check("done_rise", {31'd0, done_o}, 32'd1);
    check("final_count", {29'd0, leds_o[2:0]}, 32'd7);
    check("sb_drained", exp_q.size(), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_100mhz_i);
      check("idle_after_done", {30'd0, uart_tx_o, done_o}, 32'd3);
    end

    // Mid-frame reset: fresh run, then reset sampled at E20..E22.
    rst_i = 1'b1;
    repeat (5) @(negedge clk_100mhz_i);
    check("rst_clears_done", {31'd0, done_o}, 32'd0);
    release_reset();
    exp_q.push_back(banner[0]);
    goto(19);
    rst_i = 1'b1;
    for (int n = 20; n <= 22; n++) begin
      goto(n);
      check("midreset_vals", {22'd0, uart_tx_o, leds_o, done_o}, {22'd0, 1'b1, 8'h00, 1'b0});
    end
    release_reset();
    exp_q.push_back(banner[1]);
    goto(0);
    check("restart_idle", {31'd0, uart_tx_o}, 32'd1);
    goto(1);
    check("restart_start", {31'd0, uart_tx_o}, 32'd0);
    recv_frame(0);
    recv_frame(1);
    check("sb_drained2", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
